// File: rtl/text_write_queue.sv
// Character write queue between the I2C register stage and the text RAM write port.
// Optional macro TEXT_CLIP_EN drops off-screen characters instead of writing them.
module text_write_queue #(
  parameter int DEPTH      = 8,
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       character_change,
  input  logic [7:0]                 xtext,
  input  logic [7:0]                 ytext,
  input  logic [DATA_WIDTH-1:0]      charattr,
  input  logic                       clear_overflow,
  output logic                       ram_req,
  input  logic                       ram_grant,
  output logic                       ram_we,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 16 + DATA_WIDTH;

`ifdef TEXT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [LVL_W-1:0]      level_q;

  logic [ENTRY_W-1:0]    head_entry;
  logic [7:0]            head_x, head_y;
  logic [DATA_WIDTH-1:0] head_ca;
  logic [31:0]           head_lin;
  logic                  head_out_of_range;
  logic                  head_clip;

  logic                  pop;
  logic                  push_accept;
  logic                  req_n, we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n;

  assign head_entry = mem[head];
  assign head_y     = head_entry[ENTRY_W-1 -: 8];
  assign head_x     = head_entry[DATA_WIDTH +: 8];
  assign head_ca    = head_entry[DATA_WIDTH-1:0];

  // Linear address is computed wide and truncated to the RAM address width.
  assign head_lin          = 32'(head_y) * 32'(COLS) + 32'(head_x);
  assign head_out_of_range = (32'(head_x) >= 32'(COLS)) || (32'(head_y) >= 32'(ROWS));
  assign head_clip         = CLIP_EN && head_out_of_range;

  assign full        = (level_q == LVL_W'(DEPTH));
  assign level       = level_q;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_accept = character_change && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[tail] <= {ytext, xtext, charattr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_accept) tail <= tail + 1'b1;
      if (pop)         head <= head + 1'b1;
      case ({push_accept, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (character_change && !push_accept) overflow <= 1'b1;
      else if (clear_overflow)              overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ram_req  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      state    <= state_n;
      ram_req  <= req_n;
      ram_we   <= we_n;
      ram_addr <= addr_n;
      ram_data <= data_n;
    end
  end

  // The head stays in the FIFO until granted, so a reset mid-handshake simply loses it.
  always_comb begin
    state_n = state;
    req_n   = ram_req;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        req_n = 1'b0;
        if (level_q != '0) begin
          if (head_clip) begin
            pop = 1'b1;
          end else begin
            addr_n  = head_lin[ADDR_WIDTH-1:0];
            data_n  = head_ca;
            req_n   = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        req_n = 1'b1;
        if (ram_grant) begin
          req_n   = 1'b0;
          we_n    = 1'b1;
          pop     = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
      default: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
